// File: rtl/ct_mmu_sysmap_cfg_pkg.sv
// rtl/ct_mmu_sysmap_cfg_pkg.sv - shared constants and types for the system-map attribute table
package ct_mmu_sysmap_cfg_pkg;

    // Attribute flag layout and the flag returned on a miss or multi-hit.
    localparam int                          SYSMAP_FLG_WIDTH = 5;
    localparam logic [SYSMAP_FLG_WIDTH-1:0] SYSMAP_DEF_FLG   = 5'b10011;

    // Flag bit-field positions.
    localparam int SYSMAP_FLG_SO_BIT  = 4;  // strongly ordered
    localparam int SYSMAP_FLG_C_BIT   = 3;  // cacheable
    localparam int SYSMAP_FLG_B_BIT   = 2;  // bufferable
    localparam int SYSMAP_FLG_SH_BIT  = 1;  // shareable
    localparam int SYSMAP_FLG_SEC_BIT = 0;  // secure

    // Page-address width for the default 40-bit physical address.
    localparam int SYSMAP_ADDR_WIDTH = 28;

    // One table entry: exclusive upper bound, attribute flag, lock.
    typedef struct packed {
        logic [SYSMAP_ADDR_WIDTH-1:0] addr;
        logic [SYSMAP_FLG_WIDTH-1:0]  flg;
        logic                         lock;
    } sysmap_entry_t;

endpackage

// File: rtl/ct_mmu_sysmap_cfg_entry.sv
// rtl/ct_mmu_sysmap_cfg_entry.sv - one system-map region: bound/flag/lock registers and bound compare
//
// Optional feature macro: SYSMAP_LOCK_EN (per-entry write lock, cleared only by reset).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wsel            write strobe already decoded for this entry
//   waddr/wflg      new upper bound (page address) and flag
//   wlock           lock bit written with the entry (ignored without SYSMAP_LOCK_EN)
//   pa              lookup page address
//   flg             current flag of this entry
//   wr_ok           write is actually applied this cycle
//   lt_bound        pa < this entry's upper bound (unsigned)
module ct_mmu_sysmap_cfg_entry
    import ct_mmu_sysmap_cfg_pkg::*;
#(
    parameter int                   ADDR_WIDTH = SYSMAP_ADDR_WIDTH,
    parameter int                   FLG_WIDTH  = SYSMAP_FLG_WIDTH,
    parameter logic [FLG_WIDTH-1:0] DEF_FLG    = SYSMAP_DEF_FLG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wsel,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [FLG_WIDTH-1:0]  wflg,
    input  logic                  wlock,
    input  logic [ADDR_WIDTH-1:0] pa,
    output logic [FLG_WIDTH-1:0]  flg,
    output logic                  wr_ok,
    output logic                  lt_bound
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [FLG_WIDTH-1:0]  flg_q,  flg_d;

`ifdef SYSMAP_LOCK_EN
    logic lock_q, lock_d;

    // A locked entry ignores writes; the lock itself can only be released by reset.
    always_comb begin
        wr_ok  = wsel & ~lock_q;
        lock_d = lock_q;
        if (wr_ok) begin
            lock_d = wlock;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_wlock;
    assign unused_wlock = wlock;

    always_comb begin
        wr_ok = wsel;
    end
`endif

    always_comb begin
        addr_d = addr_q;
        flg_d  = flg_q;
        if (wr_ok) begin
            addr_d = waddr;
            flg_d  = wflg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            flg_q  <= DEF_FLG;
        end else begin
            addr_q <= addr_d;
            flg_q  <= flg_d;
        end
    end

    assign flg      = flg_q;
    assign lt_bound = (pa < addr_q);

endmodule

// File: rtl/ct_mmu_sysmap_cfg.sv
// rtl/ct_mmu_sysmap_cfg.sv - programmable system-map region table with registered attribute lookup
//
// Optional feature macro: SYSMAP_LOCK_EN (per-entry write lock).
// Ports:
//   forever_cpuclk, cpurst            clock, synchronous active-high reset
//   regs_sysmap_wen/widx/waddr/wflg   region write from CP0 registers
//   regs_sysmap_wlock                 lock bit written with the entry
//   sysmap_regs_wack                  write accepted, one cycle after wen
//   mmu_sysmap_req/pa                 lookup request and page address
//   sysmap_mmu_vld/hit/flg/mhit       lookup result, one cycle after req
//   sysmap_mmu_cfg_chg                one-cycle pulse after the table really changed
module ct_mmu_sysmap_cfg
    import ct_mmu_sysmap_cfg_pkg::*;
#(
    parameter int                   ENTRY_NUM = 8,
    parameter int                   PA_WIDTH  = 40,
    parameter int                   FLG_WIDTH = SYSMAP_FLG_WIDTH,
    parameter logic [FLG_WIDTH-1:0] DEF_FLG   = SYSMAP_DEF_FLG,
    localparam int                  ADDR_WIDTH = PA_WIDTH - 12,
    localparam int                  IDX_W      = $clog2(ENTRY_NUM)
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  regs_sysmap_wen,
    input  logic [IDX_W-1:0]      regs_sysmap_widx,
    input  logic [ADDR_WIDTH-1:0] regs_sysmap_waddr,
    input  logic [FLG_WIDTH-1:0]  regs_sysmap_wflg,
    input  logic                  regs_sysmap_wlock,
    output logic                  sysmap_regs_wack,
    input  logic                  mmu_sysmap_req,
    input  logic [ADDR_WIDTH-1:0] mmu_sysmap_pa,
    output logic                  sysmap_mmu_vld,
    output logic [ENTRY_NUM-1:0]  sysmap_mmu_hit,
    output logic [FLG_WIDTH-1:0]  sysmap_mmu_flg,
    output logic                  sysmap_mmu_mhit,
    output logic                  sysmap_mmu_cfg_chg
);

    logic [ENTRY_NUM-1:0] wsel;
    logic [ENTRY_NUM-1:0] wr_ok;
    logic [ENTRY_NUM-1:0] lt_bound;
    logic [ENTRY_NUM-1:0] ge_bottom;
    logic [ENTRY_NUM-1:0] hit_raw;
    logic [FLG_WIDTH-1:0] ent_flg [ENTRY_NUM];
    logic                 widx_ok;

    // Non-power-of-two tables leave some index codes unmapped.
    assign widx_ok = (32'(regs_sysmap_widx) < ENTRY_NUM);

    for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
        assign wsel[i] = regs_sysmap_wen & widx_ok & (32'(regs_sysmap_widx) == i);

        ct_mmu_sysmap_cfg_entry #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .FLG_WIDTH  (FLG_WIDTH),
            .DEF_FLG    (DEF_FLG)
        ) u_entry (
            .clk      (forever_cpuclk),
            .rst      (cpurst),
            .wsel     (wsel[i]),
            .waddr    (regs_sysmap_waddr),
            .wflg     (regs_sysmap_wflg),
            .wlock    (regs_sysmap_wlock),
            .pa       (mmu_sysmap_pa),
            .flg      (ent_flg[i]),
            .wr_ok    (wr_ok[i]),
            .lt_bound (lt_bound[i])
        );
    end

    // Region i's lower bound is region i-1's upper bound; region 0 starts at 0.
    assign ge_bottom = {~lt_bound[ENTRY_NUM-2:0], 1'b1};
    assign hit_raw   = ge_bottom & lt_bound;

    logic                 any_hit;
    logic                 multi_hit;
    logic [FLG_WIDTH-1:0] flg_or;
    logic [FLG_WIDTH-1:0] flg_sel;

    always_comb begin
        any_hit = |hit_raw;
        // Clearing the lowest set bit leaves something only when two or more bits are set.
        multi_hit = |(hit_raw & (hit_raw - {{(ENTRY_NUM-1){1'b0}}, 1'b1}));
        flg_or = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (hit_raw[i]) begin
                flg_or = flg_or | ent_flg[i];
            end
        end
        flg_sel = (any_hit && !multi_hit) ? flg_or : DEF_FLG;
    end

    logic                 vld_q,  vld_d;
    logic [ENTRY_NUM-1:0] hit_q,  hit_d;
    logic [FLG_WIDTH-1:0] flg_q,  flg_d;
    logic                 mhit_q, mhit_d;
    logic                 wack_q, wack_d;
    logic                 chg_q,  chg_d;

    // Result fields hold their last value when no lookup is issued.
    always_comb begin
        vld_d  = mmu_sysmap_req;
        hit_d  = hit_q;
        flg_d  = flg_q;
        mhit_d = mhit_q;
        if (mmu_sysmap_req) begin
            hit_d  = hit_raw;
            flg_d  = flg_sel;
            mhit_d = multi_hit;
        end
        wack_d = regs_sysmap_wen;
        chg_d  = |wr_ok;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            vld_q  <= 1'b0;
            hit_q  <= '0;
            flg_q  <= DEF_FLG;
            mhit_q <= 1'b0;
            wack_q <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            hit_q  <= hit_d;
            flg_q  <= flg_d;
            mhit_q <= mhit_d;
            wack_q <= wack_d;
            chg_q  <= chg_d;
        end
    end

    assign sysmap_mmu_vld     = vld_q;
    assign sysmap_mmu_hit     = hit_q;
    assign sysmap_mmu_flg     = flg_q;
    assign sysmap_mmu_mhit    = mhit_q;
    assign sysmap_regs_wack   = wack_q;
    assign sysmap_mmu_cfg_chg = chg_q;

endmodule

// File: tb/tb_ct_mmu_sysmap_cfg.sv
// tb/tb_ct_mmu_sysmap_cfg.sv - self-checking bench for ct_mmu_sysmap_cfg
module tb_ct_mmu_sysmap_cfg;

    localparam logic [4:0] DEF = 5'b10011;

    logic        clk;
    logic        cpurst;
    logic        wen;
    logic [2:0]  widx;
    logic [27:0] waddr;
    logic [4:0]  wflg;
    logic        wlock;
    logic        wack;
    logic        req;
    logic [27:0] pa;
    logic        vld;
    logic [7:0]  hit;
    logic [4:0]  flg;
    logic        mhit;
    logic        cfg_chg;

    ct_mmu_sysmap_cfg #(
        .ENTRY_NUM (8),
        .PA_WIDTH  (40)
    ) dut (
        .forever_cpuclk     (clk),
        .cpurst             (cpurst),
        .regs_sysmap_wen    (wen),
        .regs_sysmap_widx   (widx),
        .regs_sysmap_waddr  (waddr),
        .regs_sysmap_wflg   (wflg),
        .regs_sysmap_wlock  (wlock),
        .sysmap_regs_wack   (wack),
        .mmu_sysmap_req     (req),
        .mmu_sysmap_pa      (pa),
        .sysmap_mmu_vld     (vld),
        .sysmap_mmu_hit     (hit),
        .sysmap_mmu_flg     (flg),
        .sysmap_mmu_mhit    (mhit),
        .sysmap_mmu_cfg_chg (cfg_chg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wen;
        logic [2:0]  widx;
        logic [27:0] waddr;
        logic [4:0]  wflg;
        logic        req;
        logic [27:0] pa;
        logic        e_vld;
        logic [7:0]  e_hit;
        logic [4:0]  e_flg;
        logic        e_mhit;
        logic        e_wack;
        logic        e_cfg;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic e_vld, input logic [7:0] e_hit,
                           input logic [4:0] e_flg, input logic e_mhit,
                           input logic e_wack, input logic e_cfg);
        chk({nm, ".vld"},  32'(vld),     32'(e_vld));
        chk({nm, ".hit"},  32'(hit),     32'(e_hit));
        chk({nm, ".flg"},  32'(flg),     32'(e_flg));
        chk({nm, ".mhit"}, 32'(mhit),    32'(e_mhit));
        chk({nm, ".wack"}, 32'(wack),    32'(e_wack));
        chk({nm, ".cfg"},  32'(cfg_chg), 32'(e_cfg));
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen   = 1'b0;
        widx  = '0;
        waddr = '0;
        wflg  = '0;
        wlock = 1'b0;
        req   = 1'b0;
        pa    = '0;
    endtask

    task automatic add(input logic w, input logic [2:0] wi, input logic [27:0] wa,
                       input logic [4:0] wf, input logic r, input logic [27:0] p,
                       input logic ev, input logic [7:0] eh, input logic [4:0] ef,
                       input logic em, input logic ewk, input logic ec);
        vec_t v;
        v.wen = w;    v.widx = wi;   v.waddr = wa;  v.wflg = wf;
        v.req = r;    v.pa = p;
        v.e_vld = ev; v.e_hit = eh;  v.e_flg = ef;  v.e_mhit = em;
        v.e_wack = ewk; v.e_cfg = ec;
        vecs.push_back(v);
    endtask

    initial begin
        //   wen idx waddr       wflg      req pa          vld hit    flg       mhit wack cfg
        add(0, 0, 28'h0,       5'b00000, 1, 28'h1234,    1, 8'h00, DEF,      0, 0, 0);
        add(1, 0, 28'h80000,   5'b01111, 0, 28'h0,       0, 8'h00, DEF,      0, 1, 1);
        add(1, 1, 28'hFFFFFFF, 5'b00011, 1, 28'h7FFFF,   1, 8'h01, 5'b01111, 0, 1, 1);
        add(0, 0, 28'h0,       5'b00000, 1, 28'h80000,   1, 8'h02, 5'b00011, 0, 0, 0);
        add(0, 0, 28'h0,       5'b00000, 1, 28'h0,       1, 8'h01, 5'b01111, 0, 0, 0);
        add(0, 0, 28'h0,       5'b00000, 1, 28'hFFFFFFF, 1, 8'h00, DEF,      0, 0, 0);
        add(0, 0, 28'h0,       5'b00000, 1, 28'hFFFFFFE, 1, 8'h02, 5'b00011, 0, 0, 0);
        add(0, 0, 28'h0,       5'b00000, 0, 28'h0,       0, 8'h02, 5'b00011, 0, 0, 0);
        // same-cycle write: lookup sees old bound 0x80000, next lookup sees 0x100
        add(1, 0, 28'h100,     5'b01111, 1, 28'h200,     1, 8'h01, 5'b01111, 0, 1, 1);
        add(0, 0, 28'h0,       5'b00000, 1, 28'h200,     1, 8'h02, 5'b00011, 0, 0, 0);
        // non-monotonic bounds: e0=0x500 e1=0x300 e2=0x480
        add(1, 0, 28'h500,     5'b01111, 0, 28'h0,       0, 8'h02, 5'b00011, 0, 1, 1);
        add(1, 1, 28'h300,     5'b00011, 0, 28'h0,       0, 8'h02, 5'b00011, 0, 1, 1);
        add(1, 2, 28'h480,     5'b00001, 0, 28'h0,       0, 8'h02, 5'b00011, 0, 1, 1);
        add(0, 0, 28'h0,       5'b00000, 1, 28'h400,     1, 8'h05, DEF,      1, 0, 0);
        add(0, 0, 28'h0,       5'b00000, 1, 28'h4FF,     1, 8'h01, 5'b01111, 0, 0, 0);
        add(0, 0, 28'h0,       5'b00000, 1, 28'h470,     1, 8'h05, DEF,      1, 0, 0);
        add(0, 0, 28'h0,       5'b00000, 0, 28'h0,       0, 8'h05, DEF,      1, 0, 0);
        // top index entry
        add(1, 7, 28'h10,      5'b00111, 0, 28'h0,       0, 8'h05, DEF,      1, 1, 1);
        add(0, 0, 28'h0,       5'b00000, 1, 28'h5,       1, 8'h81, DEF,      1, 0, 0);
        add(0, 0, 28'h0,       5'b00000, 1, 28'h10,      1, 8'h01, 5'b01111, 0, 0, 0);

        idle();
        cpurst = 1'b1;
        step();
        step();
        cpurst = 1'b0;
        chk_all("reset", 0, 8'h00, DEF, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            wen   = vecs[i].wen;
            widx  = vecs[i].widx;
            waddr = vecs[i].waddr;
            wflg  = vecs[i].wflg;
            wlock = 1'b0;
            req   = vecs[i].req;
            pa    = vecs[i].pa;
            step();
            chk_all($sformatf("v%0d", i), vecs[i].e_vld, vecs[i].e_hit, vecs[i].e_flg,
                    vecs[i].e_mhit, vecs[i].e_wack, vecs[i].e_cfg);
        end

        // reset during continuous lookups
        idle();
        req = 1'b1;
        pa  = 28'h5;
        step();
        chk_all("pre_rst", 1, 8'h81, DEF, 1, 0, 0);
        cpurst = 1'b1;
        wen    = 1'b1;
        widx   = 3'd0;
        waddr  = 28'h40;
        wflg   = 5'b00110;
        step();
        chk_all("in_rst", 0, 8'h00, DEF, 0, 0, 0);
        cpurst = 1'b0;
        wen    = 1'b0;
        step();
        chk_all("post_rst_a", 1, 8'h00, DEF, 0, 0, 0);
        pa = 28'h0;
        step();
        chk_all("post_rst_b", 1, 8'h00, DEF, 0, 0, 0);

`ifdef SYSMAP_LOCK_EN
        idle();
        wen = 1'b1; widx = 3'd2; waddr = 28'h1000; wflg = 5'b00101; wlock = 1'b1;
        step();
        chk_all("lock_wr", 0, 8'h00, DEF, 0, 1, 1);
        wflg = 5'b01010; wlock = 1'b0;
        step();
        chk_all("lock_rewr", 0, 8'h00, DEF, 0, 1, 0);
        idle();
        req = 1'b1; pa = 28'h10;
        step();
        chk_all("lock_look", 1, 8'h04, 5'b00101, 0, 0, 0);
        idle();
        cpurst = 1'b1;
        step();
        cpurst = 1'b0;
        wen = 1'b1; widx = 3'd2; waddr = 28'h1000; wflg = 5'b01010; wlock = 1'b0;
        step();
        chk_all("unlock_wr", 0, 8'h00, DEF, 0, 1, 1);
        idle();
        req = 1'b1; pa = 28'h10;
        step();
        chk_all("unlock_look", 1, 8'h04, 5'b01010, 0, 0, 0);
`endif

        idle();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
